debug_cmd_sequencer: RTL and testbench
======================================

Name: debug_cmd_sequencer

Overview:
- Upstream stage of the debug decoder. Receives debug command bytes from the host-link byte interface (UART/SPI rx/tx FIFOs) and holds the debug address and data-in registers.
- Presents a stable DEBUG_OP/ARG/ADDR_INC/EN_BKP word to the decoder, strobes execution, and waits for completion from the bus/register sequencers.
- Serialises read results or a status byte back to the host.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in WAIT before aborting with the error status.
- ACK_BYTE, 8'hA5: status byte returned for write/local commands.
- ERR_BYTE, 8'hEE: status byte returned on timeout or illegal command.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESETN  in  1  synchronous active-low reset
- RX_DATA  in  8  command/argument byte from host link
- RX_VALID  in  1  RX_DATA valid
- RX_READY  out  1  sequencer accepts RX_DATA this cycle
- TX_DATA  out  8  response byte
- TX_VALID  out  1  TX_DATA valid
- TX_READY  in  1  host link accepts TX_DATA
- DEBUG_OP_O  out  3  op code to decoder (`DEBUG_OPX_*)
- DEBUG_ARG_O  out  3  arg to decoder
- DEBUG_ADDR_INC_O  out  1  per-command address auto-increment request
- DEBUG_EN_BKP_O  out  1  breakpoint enable value for WR_BKP
- DEBUG_EXEC_O  out  1  one-cycle strobe: execute the presented op
- DEBUG_DONE_I  in  1  sequencers report op complete
- DEBUG_ADDR_INCX_I  in  1  decoder's address-increment control
- DEBUG_DATA_I  in  16  debug data register (result of read ops)
- DEBUG_ADDR_O  out  16  debug address register
- DEBUG_DIN_O  out  16  debug data-in register (write data)

Behaviour:
- Reset (RESETN=0 at a clock edge):
  - State returns to IDLE, whatever the current state; any in-flight command or response is abandoned and nothing is sent on TX.
  - All outputs go to 0: DEBUG_OP_O/ARG_O=0, ADDR=0, DIN=0, TX_VALID=0, RX_READY=0, DEBUG_EXEC_O=0, timeout counter=0.
- Command byte C:
  - C[7]=0, execute: OP=C[2:0], ARG=C[5:3], ADDR_INC=C[6], EN_BKP=C[3] (ARG[0]).
  - C[7]=1, local command, selected by C[1:0]:
    - 00: NOP/ping.
    - 01: LD_ADDR, 2 bytes follow, high byte first.
    - 10: LD_DIN, 2 bytes follow, high byte first.
    - 11: illegal.
  - C[6:2] are ignored for local commands.
- RX handshake: a byte transfers when RX_VALID & RX_READY. RX_READY=1 only in IDLE, ARG_HI and ARG_LO.
- TX handshake:
  - A byte transfers when TX_VALID & TX_READY.
  - TX_DATA is held stable while TX_VALID=1 & TX_READY=0.
  - TX_VALID falls the cycle after a transfer unless another byte follows.
- State machine:
  - IDLE: on byte, latch C.
    - Execute command → ISSUE.
    - LD_ADDR/LD_DIN → ARG_HI.
    - NOP → ACK.
    - Illegal → ERR.
  - ARG_HI: on byte, store bits [15:8] of the target register → ARG_LO.
  - ARG_LO: on byte, store bits [7:0] → ACK. The register updates as each byte arrives; no side-effect on the decoder.
  - ISSUE:
    - DEBUG_OP/ARG/ADDR_INC/EN_BKP have been stable since C was latched.
    - DEBUG_EXEC_O=1 for exactly this one cycle; clear the timeout counter → WAIT.
  - WAIT:
    - Counter increments each cycle.
    - On DEBUG_DONE_I=1:
      - If DEBUG_ADDR_INCX_I=1, ADDR<=ADDR+1 (16-bit wrap, FFFF→0000).
      - Capture DEBUG_DATA_I into the response register.
      - Read ops (RD_REG, RD_CC, RD_PC, RD_INSTRUCTION, RD_MEM) → RESP_HI; all other ops → ACK.
    - If the counter reaches TIMEOUT_CYCLES with no DONE → ERR.
    - DONE and timeout in the same cycle: DONE wins.
    - DONE is ignored in every state other than WAIT.
  - RESP_HI: send data[15:8]; on transfer → RESP_LO.
  - RESP_LO: send data[7:0]; on transfer → IDLE.
  - ACK: send ACK_BYTE; on transfer → IDLE.
  - ERR: send ERR_BYTE; on transfer → IDLE. ADDR is not modified.
- Op-to-decoder latency: EXEC asserts 1 cycle after the command byte is accepted. The decoder inputs hold their values until the next command byte is accepted.
- Back-to-back commands: the next command is accepted only after the previous response has fully transferred. There is no pipelining and no overlap.
- DEBUG_DIN_O and DEBUG_ADDR_O change only via LD_DIN/LD_ADDR, auto-increment, or reset.

Test Plan:
- LD_ADDR: bytes 0x81,0x12,0x34 → DEBUG_ADDR_O=0x1234 after the third byte; TX sends 0xA5 once; no EXEC pulse.
- RD_MEM with increment (ADDR=0x1234):
  - Stimulus: command with C[6]=1; DONE returned 3 cycles after EXEC with DATA_I=0xBEEF and ADDR_INCX_I=1.
  - Required: exactly one EXEC pulse; TX sends 0xBE then 0xEF; ADDR=0x1235.
- Address wrap: ADDR=0xFFFF, read op with ADDR_INCX_I=1 at DONE → ADDR=0x0000.
- TX backpressure: hold TX_READY=0 for 10 cycles during RESP_HI → TX_DATA stable and TX_VALID=1 throughout; RX_READY=0; bytes delivered in order once TX_READY=1.
- Timeout and illegal command:
  - Issue WR_MEM and never assert DONE → ERR_BYTE 0xEE after TIMEOUT_CYCLES; ADDR unchanged.
  - Command 0x83 → 0xEE.
  - DONE asserted on the exact timeout cycle → normal ACK.
- Reset mid-operation: assert RESETN=0 in WAIT and again in RESP_LO → all outputs 0, state IDLE, no TX byte emitted; a new command works normally afterwards.

Source files
------------

// File: rtl/debug_cmd_sequencer_if.sv
// debug_cmd_sequencer_if: host-link byte streams plus debug decoder/sequencer signals
interface debug_cmd_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  debug_op;
  logic [2:0]  debug_arg;
  logic        debug_addr_inc;
  logic        debug_en_bkp;
  logic        debug_exec;
  logic        debug_done;
  logic        debug_addr_incx;
  logic [15:0] debug_data;
  logic [15:0] debug_addr;
  logic [15:0] debug_din;
  modport master (
    output rx_data, rx_valid, tx_ready, debug_done, debug_addr_incx, debug_data,
    input  rx_ready, tx_data, tx_valid, debug_op, debug_arg, debug_addr_inc,
           debug_en_bkp, debug_exec, debug_addr, debug_din
  );
  modport slave (
    input  rx_data, rx_valid, tx_ready, debug_done, debug_addr_incx, debug_data,
    output rx_ready, tx_data, tx_valid, debug_op, debug_arg, debug_addr_inc,
           debug_en_bkp, debug_exec, debug_addr, debug_din
  );
endinterface

// File: rtl/debug_cmd_sequencer.sv
// debug_cmd_sequencer: parses host command bytes, drives the debug decoder and returns results
module debug_cmd_sequencer #(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] ACK_BYTE       = 8'hA5,
  parameter logic [7:0] ERR_BYTE       = 8'hEE
) (
  input logic i_clk,
  input logic i_resetn,
  debug_cmd_sequencer_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // op encoding: 0 RD_REG, 1 RD_CC, 2 RD_PC, 3 RD_INSTRUCTION, 4 RD_MEM, 5 WR_REG, 6 WR_MEM, 7 WR_BKP
  localparam logic [2:0] OP_LAST_READ = 3'd4;
  typedef enum logic [3:0] {
    S_IDLE, S_ARG_HI, S_ARG_LO, S_ISSUE, S_WAIT, S_RESP_HI, S_RESP_LO, S_ACK, S_ERR
  } state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_op, r_arg;
  logic        r_inc, r_sel;
  logic [15:0] r_addr, r_din, r_resp;
  logic [CW-1:0] r_cnt;
  logic        w_rx_fire, w_tx_fire, w_timeout;
  assign w_rx_fire = bus.rx_valid & bus.rx_ready;
  assign w_tx_fire = bus.tx_valid & bus.tx_ready;
  assign w_timeout = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign bus.rx_ready = i_resetn & (r_state inside {S_IDLE, S_ARG_HI, S_ARG_LO});
  assign bus.tx_valid = r_state inside {S_RESP_HI, S_RESP_LO, S_ACK, S_ERR};
  assign bus.tx_data = r_state == S_RESP_HI ? r_resp[15:8] :
                       r_state == S_RESP_LO ? r_resp[7:0]  :
                       r_state == S_ACK     ? ACK_BYTE     :
                       r_state == S_ERR     ? ERR_BYTE     : 8'h00;
  assign bus.debug_exec     = r_state == S_ISSUE;
  assign bus.debug_op       = r_op;
  assign bus.debug_arg      = r_arg;
  assign bus.debug_addr_inc = r_inc;
  assign bus.debug_en_bkp   = r_arg[0];
  assign bus.debug_addr     = r_addr;
  assign bus.debug_din      = r_din;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_rx_fire) w_next = !bus.rx_data[7]          ? S_ISSUE :
                                         bus.rx_data[1:0] == 2'b00 ? S_ACK   :
                                         bus.rx_data[1:0] == 2'b11 ? S_ERR   : S_ARG_HI;
      S_ARG_HI:  if (w_rx_fire) w_next = S_ARG_LO;
      S_ARG_LO:  if (w_rx_fire) w_next = S_ACK;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (bus.debug_done) w_next = r_op <= OP_LAST_READ ? S_RESP_HI : S_ACK;
                 else if (w_timeout) w_next = S_ERR;
      S_RESP_HI: if (w_tx_fire) w_next = S_RESP_LO;
      S_RESP_LO, S_ACK, S_ERR: if (w_tx_fire) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_arg   <= '0;
      r_inc   <= 1'b0;
      r_sel   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_resp  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_state == S_WAIT ? r_cnt + 1'b1 : '0;
      if (w_rx_fire && r_state == S_IDLE) begin
        r_sel <= bus.rx_data[1];
        if (!bus.rx_data[7]) {r_inc, r_arg, r_op} <= bus.rx_data[6:0];
      end
      if (w_rx_fire && r_state == S_ARG_HI) begin
        if (r_sel) r_din[15:8] <= bus.rx_data;
        else r_addr[15:8] <= bus.rx_data;
      end
      if (w_rx_fire && r_state == S_ARG_LO) begin
        if (r_sel) r_din[7:0] <= bus.rx_data;
        else r_addr[7:0] <= bus.rx_data;
      end
      if (r_state == S_WAIT && bus.debug_done) begin
        r_resp <= bus.debug_data;
        if (bus.debug_addr_incx) r_addr <= r_addr + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// tb_debug_cmd_sequencer: directed and random commands checked against a command-level model
module tb_debug_cmd_sequencer;
  localparam int         TO  = 255;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] ERR = 8'hEE;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int failures = 0;
  int exec_cnt = 0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_din = '0;
  debug_cmd_sequencer_if bus();
  debug_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .ACK_BYTE(ACK), .ERR_BYTE(ERR)) dut (
    .i_clk(clk), .i_resetn(resetn), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.debug_exec === 1'b1) exec_cnt++;
  function automatic bit is_read(input logic [2:0] op);
    return op inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {bus.rx_ready, bus.tx_valid, bus.tx_data, bus.debug_exec, bus.debug_op, bus.debug_arg,
              bus.debug_addr_inc, bus.debug_en_bkp, bus.debug_addr, bus.debug_din}, 64'h0);
  endtask
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (bus.rx_ready !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    chk("rx_ready_wait", bus.rx_ready, 1);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask
  task automatic get_byte(input int stall, output logic [7:0] b);
    int t = 0;
    logic [7:0] first;
    bit ok = 1'b1;
    while (bus.tx_valid !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    chk("tx_valid_wait", bus.tx_valid, 1);
    first = bus.tx_data;
    repeat (stall) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== first || bus.rx_ready !== 1'b0) ok = 1'b0;
    end
    if (stall > 0) chk("tx_hold", ok, 1);
    bus.tx_ready = 1'b1;
    b = bus.tx_data;
    @(negedge clk);
    bus.tx_ready = 1'b0;
  endtask
  task automatic expect_resp(input int n, input logic [15:0] exp, input int stall);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      get_byte(stall, b);
      chk("tx_byte", b, (n == 2 && k == 0) ? exp[15:8] : exp[7:0]);
    end
    chk("tx_idle", bus.tx_valid, 0);
  endtask
  task automatic issue(input logic [7:0] c, input int delay, input bit incx, input logic [15:0] data);
    int lim = delay == 0 ? TO + 5 : delay;
    send_byte(c);
    chk("exec_issue", bus.debug_exec, 1);
    chk("decoder_word", {bus.debug_op, bus.debug_arg, bus.debug_addr_inc, bus.debug_en_bkp},
        {c[2:0], c[5:3], c[6], c[3]});
    for (int j = 1; j <= lim; j++) begin
      @(negedge clk);
      bus.debug_done = j == delay;
      bus.debug_addr_incx = (j == delay) ? incx : 1'($urandom);
      bus.debug_data = (j == delay) ? data : 16'($urandom);
    end
    @(negedge clk);
    bus.debug_done = 1'b0;
  endtask
  task automatic exec_cmd(input logic [7:0] c, input int delay, input bit incx,
                          input logic [15:0] data, input int stall);
    int e0 = exec_cnt;
    if (delay >= 1 && delay <= TO) begin
      if (incx) m_addr = m_addr + 16'd1;
      issue(c, delay, incx, data);
      if (is_read(c[2:0])) expect_resp(2, data, stall);
      else expect_resp(1, {8'h00, ACK}, stall);
    end else begin
      issue(c, delay, incx, data);
      expect_resp(1, {8'h00, ERR}, stall);
    end
    chk("exec_once", exec_cnt - e0, 1);
    chk("addr", bus.debug_addr, m_addr);
    chk("din", bus.debug_din, m_din);
    chk("decoder_hold", {bus.debug_op, bus.debug_arg, bus.debug_addr_inc}, {c[2:0], c[5:3], c[6]});
  endtask
  task automatic ld(input logic [7:0] c, input logic [15:0] v, input int stall);
    int e0 = exec_cnt;
    send_byte(c);
    send_byte(v[15:8]);
    send_byte(v[7:0]);
    if (c[1]) m_din = v;
    else m_addr = v;
    expect_resp(1, {8'h00, ACK}, stall);
    chk("ld_addr", bus.debug_addr, m_addr);
    chk("ld_din", bus.debug_din, m_din);
    chk("ld_no_exec", exec_cnt - e0, 0);
  endtask
  task automatic local_cmd(input logic [7:0] c, input logic [7:0] exp);
    int e0 = exec_cnt;
    send_byte(c);
    expect_resp(1, {8'h00, exp}, $urandom_range(0, 3));
    chk("local_no_exec", exec_cnt - e0, 0);
  endtask
  initial begin
    logic [7:0] b;
    logic [7:0] c;
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    bus.debug_done = 1'b0; bus.debug_addr_incx = 1'b0; bus.debug_data = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    resetn = 1'b1;
    @(negedge clk);
    ld(8'h81, 16'h1234, 0);
    exec_cmd(8'h44, 3, 1'b1, 16'hBEEF, 0);
    ld(8'h82, 16'hCAFE, 2);
    ld(8'hFD, 16'hFFFF, 1);
    exec_cmd(8'h01, 2, 1'b1, 16'h55AA, 0);
    chk("addr_wrap", bus.debug_addr, 16'h0000);
    exec_cmd(8'h03, 4, 1'b0, 16'h0F0F, 10);
    exec_cmd(8'h06, 0, 1'b1, 16'h0000, 0);
    local_cmd(8'h83, ERR);
    local_cmd(8'hFF, ERR);
    local_cmd(8'h80, ACK);
    exec_cmd(8'h0F, TO, 1'b1, 16'h1111, 0);
    exec_cmd(8'h02, TO + 1, 1'b1, 16'h2222, 0);
    send_byte(8'h04);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk_zero("reset_in_wait");
    resetn = 1'b1;
    m_addr = '0; m_din = '0;
    @(negedge clk);
    chk("no_tx_after_reset_wait", bus.tx_valid, 0);
    issue(8'h04, 2, 1'b0, 16'h1357);
    get_byte(0, b);
    chk("resp_hi_before_reset", b, 8'h13);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk_zero("reset_in_resp_lo");
    resetn = 1'b1;
    @(negedge clk);
    chk("no_tx_after_reset_resp", bus.tx_valid, 0);
    ld(8'h81, 16'h00F0, 0);
    exec_cmd(8'h4C, 1, 1'b1, 16'hA1B2, 1);
    for (int i = 0; i < 30; i++) begin
      int kind = $urandom_range(0, 5);
      if (kind == 0) ld({1'b1, 5'($urandom), 1'b0, 1'($urandom)} | 8'h01, 16'($urandom), $urandom_range(0, 3));
      else if (kind == 1) local_cmd({1'b1, 5'($urandom), 2'b00}, ACK);
      else if (kind == 2) local_cmd({1'b1, 5'($urandom), 2'b11}, ERR);
      else begin
        c = {1'b0, 7'($urandom)};
        exec_cmd(c, $urandom_range(1, 8), 1'($urandom), 16'($urandom), $urandom_range(0, 3));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
